// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage program-counter generator.
// Latency: n/a (types, constants and one helper only).
// Backpressure: n/a.
package pc_pkg;

    // Next-PC source select; encodings 5-7 decode as PC_SEQ
    typedef enum logic [2:0] {
        PC_SEQ    = 3'd0,
        PC_BRANCH = 3'd1,
        PC_JALR   = 3'd2,
        PC_TRAP   = 3'd3,
        PC_MRET   = 3'd4
    } pc_sel_e;

    // Control FSM: one idle cycle after reset, normal running, redirect buffered
    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_HOLD  = 2'd2
    } pc_state_e;

    localparam int unsigned PC_INC_DEFAULT    = 4;
    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

    // True when a fetch target is not word aligned
    function automatic logic low_bits_set(input logic [1:0] lsb);
        return |lsb;
    endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Decodes pc_sel into a redirect flag and target address (JALR bit 0 cleared).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the owner decides whether and when the target is applied.
module pc_target_mux
    import pc_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      pc_sel,
    input  logic [XLEN-1:0] branch_tgt,
    input  logic [XLEN-1:0] jalr_tgt,
    input  logic [XLEN-1:0] trap_vec,
    input  logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] target,
    output logic            redirect,
    output logic            align_chk
);

    // Select target; trap vectors are trusted and never alignment-checked
    always_comb begin
        target    = '0;
        redirect  = 1'b0;
        align_chk = 1'b0;
        case (pc_sel)
            PC_BRANCH: begin
                target    = branch_tgt;
                redirect  = 1'b1;
                align_chk = 1'b1;
            end
            PC_JALR: begin
                target    = {jalr_tgt[XLEN-1:1], 1'b0};
                redirect  = 1'b1;
                align_chk = 1'b1;
            end
            PC_TRAP: begin
                target    = trap_vec;
                redirect  = 1'b1;
                align_chk = 1'b0;
            end
            PC_MRET: begin
                target    = mepc;
                redirect  = 1'b1;
                align_chk = 1'b1;
            end
            default: begin
                target    = '0;
                redirect  = 1'b0;
                align_chk = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Architectural PC register with next-PC selection and a valid/ready fetch request port.
// Latency: redirect or accepted fetch updates fetch_addr on the next cycle; one request per cycle.
// Backpressure: fetch_addr held while fetch_ready is low; redirects buffered one-deep (PC_ALIGN_CHECK_EN enables target alignment checks).
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEFAULT),
    parameter int unsigned     PC_INC    = PC_INC_DEFAULT
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [2:0]      pc_sel,
    input  logic [XLEN-1:0] branch_tgt,
    input  logic [XLEN-1:0] jalr_tgt,
    input  logic [XLEN-1:0] trap_vec,
    input  logic [XLEN-1:0] mepc,
    input  logic            stall,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_addr,
    output logic [XLEN-1:0] pc_out,
    output logic            redirect_pending,
    output logic            misalign_err,
    output logic [XLEN-1:0] misalign_addr
);

    localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

    pc_state_e       state_q;
    pc_state_e       state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pend_q;
    logic            open_q;

    logic [XLEN-1:0] tgt;
    logic            redir_raw;
    logic            chk;
    logic            redir_bad;
    logic            redir;
    logic            hs;
    logic            open;

    pc_target_mux #(
        .XLEN (XLEN)
    ) u_mux (
        .pc_sel     (pc_sel),
        .branch_tgt (branch_tgt),
        .jalr_tgt   (jalr_tgt),
        .trap_vec   (trap_vec),
        .mepc       (mepc),
        .target     (tgt),
        .redirect   (redir_raw),
        .align_chk  (chk)
    );

`ifdef PC_ALIGN_CHECK_EN
    // A rejected redirect freezes pc_q, pend_q and the FSM for that cycle
    assign redir_bad = redir_raw & chk & low_bits_set(tgt[1:0]);
`else
    logic unused_chk;
    assign unused_chk = chk;
    assign redir_bad  = 1'b0;
`endif

    assign redir = redir_raw & ~redir_bad;
    assign hs    = fetch_valid & fetch_ready;
    assign open  = fetch_valid & ~fetch_ready;

    assign fetch_addr = pc_q;
    assign pc_out     = pc_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: redirect during an open request parks it; handshake releases it
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_RUN;
            S_RUN:   if (redir && open) state_d = S_HOLD;
            S_HOLD:  if (hs && !redir_bad) state_d = S_RUN;
            default: state_d = S_RESET;
        endcase
    end

    // Outputs: once a request is open it stays valid until taken, even under stall
    always_comb begin
        fetch_valid      = (state_q != S_RESET) & ~(stall & ~open_q);
        redirect_pending = (state_q == S_HOLD);
    end

    // PC, pending-target and open-request registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_q   <= RESET_VEC;
            pend_q <= '0;
            open_q <= 1'b0;
        end else begin
            open_q <= open;
            case (state_q)
                S_RESET: begin
                    if (redir) pc_q <= tgt;
                end
                S_RUN: begin
                    if (redir) begin
                        if (open) pend_q <= tgt;
                        else      pc_q   <= tgt;
                    end else if (!redir_bad && hs && !stall) begin
                        pc_q <= pc_q + INC;
                    end
                end
                S_HOLD: begin
                    // Latest redirect wins, including one arriving with the handshake
                    if (hs) begin
                        if (redir)           pc_q <= tgt;
                        else if (!redir_bad) pc_q <= pend_q;
                    end else if (redir) begin
                        pend_q <= tgt;
                    end
                end
                default: begin
                    pc_q <= pc_q;
                end
            endcase
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic            mis_err_q;
    logic [XLEN-1:0] mis_addr_q;

    // One-cycle error pulse carrying the rejected target
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mis_err_q  <= 1'b0;
            mis_addr_q <= '0;
        end else begin
            mis_err_q <= redir_bad;
            if (redir_bad) mis_addr_q <= tgt;
        end
    end

    assign misalign_err  = mis_err_q;
    assign misalign_addr = mis_addr_q;
`else
    assign misalign_err  = 1'b0;
    assign misalign_addr = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios with literal expectations plus randomized traffic.
// Latency: model predicts outputs cycle by cycle from the redirect/handshake rules.
// Backpressure: random fetch_ready and stall exercise held requests and buffered redirects.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  pc_sel;
    logic [31:0] branch_tgt;
    logic [31:0] jalr_tgt;
    logic [31:0] trap_vec;
    logic [31:0] mepc;
    logic        stall;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_addr;
    logic [31:0] pc_out;
    logic        redirect_pending;
    logic        misalign_err;
    logic [31:0] misalign_addr;

    int total = 0;
    int bad   = 0;

    // Reference model state (describes the DUT after the next rising edge once updated)
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    bit          m_hold;
    bit          m_started;
    bit          m_open_prev;
    bit          m_mis;
    logic [31:0] m_mis_addr;

    pc_gen u_dut (
        .clk              (clk),
        .rstn             (rstn),
        .pc_sel           (pc_sel),
        .branch_tgt       (branch_tgt),
        .jalr_tgt         (jalr_tgt),
        .trap_vec         (trap_vec),
        .mepc             (mepc),
        .stall            (stall),
        .fetch_valid      (fetch_valid),
        .fetch_ready      (fetch_ready),
        .fetch_addr       (fetch_addr),
        .pc_out           (pc_out),
        .redirect_pending (redirect_pending),
        .misalign_err     (misalign_err),
        .misalign_addr    (misalign_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT to model, then advance the model by this cycle's inputs
    task automatic model_step();
        bit          exp_valid;
        bit          redirect;
        bit          rejected;
        bit          accepted;
        bit          still_open;
        logic [31:0] t;
        if (!rstn) begin
            m_pc = 32'h0; m_pend = 32'h0; m_hold = 0; m_started = 0;
            m_open_prev = 0; m_mis = 0; m_mis_addr = 32'h0;
            return;
        end
        exp_valid = m_started && !(stall && !m_open_prev);
        chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, exp_valid});
        chk("fetch_addr", fetch_addr, m_pc);
        chk("pc_out", pc_out, m_pc);
        chk("redirect_pending", {31'b0, redirect_pending}, {31'b0, m_hold});
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
        chk("misalign_addr", misalign_addr, m_mis_addr);

        redirect = 1;
        t = 32'h0;
        case (pc_sel)
            3'd1: t = branch_tgt;
            3'd2: t = {jalr_tgt[31:1], 1'b0};
            3'd3: t = trap_vec;
            3'd4: t = mepc;
            default: redirect = 0;
        endcase
        rejected = 0;
`ifdef PC_ALIGN_CHECK_EN
        rejected = redirect && (pc_sel != 3'd3) && (t[1:0] != 2'b00);
        m_mis = rejected;
        if (rejected) m_mis_addr = t;
`endif
        accepted   = exp_valid && fetch_ready;
        still_open = exp_valid && !fetch_ready;
        if (rejected) begin
            m_started = 1;
        end else if (!m_started) begin
            if (redirect) m_pc = t;
            m_started = 1;
        end else if (m_hold) begin
            if (accepted) begin
                m_pc   = redirect ? t : m_pend;
                m_hold = 0;
            end else if (redirect) begin
                m_pend = t;
            end
        end else if (redirect) begin
            if (still_open) begin
                m_pend = t;
                m_hold = 1;
            end else begin
                m_pc = t;
            end
        end else if (accepted && !stall) begin
            m_pc = m_pc + 32'd4;
        end
        m_open_prev = still_open;
    endtask

    // One clock: model check at the falling edge, return just after the rising edge
    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] base_pc;
        rstn = 1'b0; pc_sel = 3'd0; stall = 1'b0; fetch_ready = 1'b1;
        branch_tgt = 32'h0; jalr_tgt = 32'h0; trap_vec = 32'h0; mepc = 32'h0;
        @(posedge clk); #1;
        tick();
        tick();
        chk("rst_valid", {31'b0, fetch_valid}, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_pending", {31'b0, redirect_pending}, 32'h0);
        chk("rst_misalign", {31'b0, misalign_err}, 32'h0);

        // Sequential fetch after reset release
        rstn = 1'b1;
        tick();
        chk("seq0_valid", {31'b0, fetch_valid}, 32'h1);
        chk("seq0_addr", fetch_addr, 32'h0);
        tick();
        chk("seq1_addr", fetch_addr, 32'h4);
        tick();
        chk("seq2_addr", fetch_addr, 32'h8);

        // JALR clears bit 0
        pc_sel = 3'd2; jalr_tgt = 32'h0000_1235;
        tick();
        pc_sel = 3'd0;
        chk("jalr_addr", fetch_addr, 32'h0000_1234);

        // Buffered redirects while request is open: latest wins
        pc_sel = 3'd1; branch_tgt = 32'h10;
        tick();
        pc_sel = 3'd1; branch_tgt = 32'h200; fetch_ready = 1'b0;
        tick();
        pc_sel = 3'd0;
        tick();
        pc_sel = 3'd3; trap_vec = 32'h80;
        tick();
        pc_sel = 3'd0;
        chk("hold_addr", fetch_addr, 32'h10);
        chk("hold_pending", {31'b0, redirect_pending}, 32'h1);
        fetch_ready = 1'b1;
        tick();
        chk("hold_release_addr", fetch_addr, 32'h80);
        chk("hold_release_pending", {31'b0, redirect_pending}, 32'h0);

        // Stall with no open request blocks the request
        stall = 1'b1;
        #1;
        chk("stall_idle_valid", {31'b0, fetch_valid}, 32'h0);
        tick();
        chk("stall_idle_pc", pc_out, 32'h80);
        // Stall after a request opened keeps it valid
        stall = 1'b0; fetch_ready = 1'b0;
        tick();
        stall = 1'b1;
        #1;
        chk("stall_open_valid0", {31'b0, fetch_valid}, 32'h1);
        tick();
        chk("stall_open_valid1", {31'b0, fetch_valid}, 32'h1);
        fetch_ready = 1'b1;
        tick();
        chk("stall_after_hs_valid", {31'b0, fetch_valid}, 32'h0);
        chk("stall_after_hs_pc", pc_out, 32'h80);
        stall = 1'b0;

        // Adder wrap
        pc_sel = 3'd1; branch_tgt = 32'hFFFF_FFFC;
        tick();
        pc_sel = 3'd0;
        chk("wrap_pre", fetch_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_post", fetch_addr, 32'h0);

        // Misaligned branch target
        base_pc = fetch_addr;
        pc_sel = 3'd1; branch_tgt = 32'h102;
        tick();
        pc_sel = 3'd0;
`ifdef PC_ALIGN_CHECK_EN
        chk("misalign_pc_held", fetch_addr, base_pc);
        chk("misalign_err_pulse", {31'b0, misalign_err}, 32'h1);
        chk("misalign_addr_val", misalign_addr, 32'h102);
        tick();
        chk("misalign_err_drop", {31'b0, misalign_err}, 32'h0);
`else
        chk("misalign_applied", fetch_addr, 32'h102);
        chk("misalign_err_tied", {31'b0, misalign_err}, 32'h0);
        tick();
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rstn        = ($urandom_range(0, 299) != 0);
            stall       = ($urandom_range(0, 4) == 0);
            fetch_ready = ($urandom_range(0, 9) < 7);
            pc_sel      = ($urandom_range(0, 9) < 6) ? 3'd0 : 3'($urandom_range(0, 7));
            branch_tgt  = $urandom & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            jalr_tgt    = $urandom;
            trap_vec    = $urandom & 32'hFFFF_FFFC;
            mepc        = $urandom & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            if ($urandom_range(0, 19) == 0) branch_tgt = 32'hFFFF_FFF8;
            tick();
        end
        rstn = 1'b1; pc_sel = 3'd0; stall = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
